qsys_dp_data_mem_pipe: RTL and testbench

Parametrised true dual-port on-chip data memory with two independent Avalon-MM slave ports (A, B) on a single clock. Successor to the fixed 256x32 dual-port data memory. Adds:
- configurable width, depth and read latency
- readdatavalid pipelining
- defined mixed-port read-during-write forwarding
- same-address write-collision arbitration via waitrequest

Sits between the Nios II data master / vision DMA and the shared scratch buffer in the Qsys system.

---
 rtl/qsys_dp_data_mem_pipe_if.sv | 27 ++
 rtl/qsys_dp_data_mem_pipe.sv | 189 ++++++++++++++++++
 tb/tb_qsys_dp_data_mem_pipe.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qsys_dp_data_mem_pipe_if.sv
// Avalon-MM slave port bundle for one port of qsys_dp_data_mem_pipe.
interface qsys_dp_data_mem_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/qsys_dp_data_mem_pipe.sv
// Parametrised true dual-port data memory with two Avalon-MM slave ports on one clock.
// Optional power-up zero scrub is enabled by defining QSYS_DP_DATA_MEM_SCRUB_EN.
module qsys_dp_data_mem_pipe #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    qsys_dp_data_mem_pipe_if.slave a,
    qsys_dp_data_mem_pipe_if.slave b
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("qsys_dp_data_mem_pipe: READ_LATENCY must be 1 or 2");
    end
    if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_width
        $error("qsys_dp_data_mem_pipe: DATA_W must be a non-zero multiple of 8");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              scrub_busy_c;
    logic              scrub_we_c;
    logic [ADDR_W-1:0] scrub_addr;

    logic              wr_coll_c;
    logic              a_acc_c, b_acc_c;
    logic              a_wr_c, b_wr_c;
    logic              a_rd_c, b_rd_c;
    logic [DATA_W-1:0] a_fwd_c, b_fwd_c;

    logic              a_s1_vld, b_s1_vld;
    logic [DATA_W-1:0] a_s1_data, b_s1_data;

    // Replace the enabled byte lanes of old_word with those of new_word.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

`ifdef QSYS_DP_DATA_MEM_SCRUB_EN
    typedef enum logic {
        ST_SCRUB = 1'b0,
        ST_READY = 1'b1
    } scrub_state_e;

    scrub_state_e state, state_nxt;

    always_ff @(posedge clk or negedge reset_n) begin : p_state
        if (!reset_n) begin
            state <= ST_SCRUB;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin : p_scrub_cnt
        if (!reset_n) begin
            scrub_addr <= '0;
        end else if (state == ST_SCRUB) begin
            scrub_addr <= scrub_addr + ADDR_W'(1);
        end
    end

    always_comb begin : p_next_state
        state_nxt = state;
        if (state == ST_SCRUB && scrub_addr == '1) begin
            state_nxt = ST_READY;
        end
    end

    // Ports stall for the whole scrub and while reset is held.
    always_comb begin : p_scrub_out
        scrub_we_c   = 1'b0;
        scrub_busy_c = ~reset_n;
        if (state == ST_SCRUB) begin
            scrub_we_c   = reset_n;
            scrub_busy_c = 1'b1;
        end
    end
`else
    assign scrub_we_c   = 1'b0;
    assign scrub_busy_c = 1'b0;
    assign scrub_addr   = '0;
`endif

    // Same-address write-write: A wins, B is stalled and retries next cycle.
    always_comb begin : p_accept
        wr_coll_c = a.chipselect & a.write & b.chipselect & b.write
                  & (a.address == b.address);
        a_acc_c   = a.chipselect & (a.read | a.write) & ~scrub_busy_c;
        b_acc_c   = b.chipselect & (b.read | b.write) & ~scrub_busy_c & ~wr_coll_c;
        a_wr_c    = a_acc_c & a.write;
        b_wr_c    = b_acc_c & b.write;
        a_rd_c    = a_acc_c & a.read & ~a.write;
        b_rd_c    = b_acc_c & b.read & ~b.write;
    end

    assign a.waitrequest = scrub_busy_c;
    assign b.waitrequest = scrub_busy_c | wr_coll_c;

    always_ff @(posedge clk) begin : p_mem_wr
        if (scrub_we_c) begin
            mem[scrub_addr] <= '0;
        end
        if (a_wr_c) begin
            mem[a.address] <= byte_merge(mem[a.address], a.writedata, a.byteenable);
        end
        if (b_wr_c) begin
            mem[b.address] <= byte_merge(mem[b.address], b.writedata, b.byteenable);
        end
    end

    // Mixed-port read-during-write returns new bytes for the other port's enabled lanes.
    always_comb begin : p_forward
        a_fwd_c = mem[a.address];
        b_fwd_c = mem[b.address];
        if (b_wr_c && b.address == a.address) begin
            a_fwd_c = byte_merge(a_fwd_c, b.writedata, b.byteenable);
        end
        if (a_wr_c && a.address == b.address) begin
            b_fwd_c = byte_merge(b_fwd_c, a.writedata, a.byteenable);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin : p_rd_s1
        if (!reset_n) begin
            a_s1_vld  <= 1'b0;
            b_s1_vld  <= 1'b0;
            a_s1_data <= '0;
            b_s1_data <= '0;
        end else begin
            a_s1_vld <= a_rd_c;
            b_s1_vld <= b_rd_c;
            if (a_rd_c) begin
                a_s1_data <= a_fwd_c;
            end
            if (b_rd_c) begin
                b_s1_data <= b_fwd_c;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic              a_s2_vld, b_s2_vld;
        logic [DATA_W-1:0] a_s2_data, b_s2_data;

        always_ff @(posedge clk or negedge reset_n) begin : p_rd_s2
            if (!reset_n) begin
                a_s2_vld  <= 1'b0;
                b_s2_vld  <= 1'b0;
                a_s2_data <= '0;
                b_s2_data <= '0;
            end else begin
                a_s2_vld <= a_s1_vld;
                b_s2_vld <= b_s1_vld;
                if (a_s1_vld) begin
                    a_s2_data <= a_s1_data;
                end
                if (b_s1_vld) begin
                    b_s2_data <= b_s1_data;
                end
            end
        end

        assign a.readdata      = a_s2_data;
        assign a.readdatavalid = a_s2_vld;
        assign b.readdata      = b_s2_data;
        assign b.readdatavalid = b_s2_vld;
    end else begin : g_lat1
        assign a.readdata      = a_s1_data;
        assign a.readdatavalid = a_s1_vld;
        assign b.readdata      = b_s1_data;
        assign b.readdatavalid = b_s1_vld;
    end
endmodule

// File: tb/tb_qsys_dp_data_mem_pipe.sv
// Self-checking bench: LAT=1 dual-port instance against a queue-based model, plus a LAT=2 instance.
module tb_qsys_dp_data_mem_pipe;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    qsys_dp_data_mem_pipe_if #(.DATA_W(32), .ADDR_W(8)) ia1 ();
    qsys_dp_data_mem_pipe_if #(.DATA_W(32), .ADDR_W(8)) ib1 ();
    qsys_dp_data_mem_pipe_if #(.DATA_W(32), .ADDR_W(4)) ia2 ();
    qsys_dp_data_mem_pipe_if #(.DATA_W(32), .ADDR_W(4)) ib2 ();

    qsys_dp_data_mem_pipe #(.DATA_W(32), .ADDR_W(8), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .a(ia1), .b(ib1));
    qsys_dp_data_mem_pipe #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .a(ia2), .b(ib2));

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } rd_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    int unsigned va_cnt = 0;
    int unsigned vb_cnt = 0;
    logic [31:0] m1 [256];
    rd_t         qa [$];
    rd_t         qb [$];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    logic        b_stalled = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic drv_a1(input logic cs, input logic rd, input logic wr, input logic [7:0] ad,
                          input logic [3:0] be, input logic [31:0] wd);
        ia1.chipselect = cs; ia1.read = rd; ia1.write = wr;
        ia1.address = ad; ia1.byteenable = be; ia1.writedata = wd;
    endtask

    task automatic drv_b1(input logic cs, input logic rd, input logic wr, input logic [7:0] ad,
                          input logic [3:0] be, input logic [31:0] wd);
        ib1.chipselect = cs; ib1.read = rd; ib1.write = wr;
        ib1.address = ad; ib1.byteenable = be; ib1.writedata = wd;
    endtask

    task automatic idle2();
        ia2.chipselect = 0; ia2.read = 0; ia2.write = 0; ia2.address = '0; ia2.byteenable = '0; ia2.writedata = '0;
        ib2.chipselect = 0; ib2.read = 0; ib2.write = 0; ib2.address = '0; ib2.byteenable = '0; ib2.writedata = '0;
    endtask

    // One clock of dut1: predict from the request rules, advance, then score the outputs.
    task automatic tick1();
        logic coll, a_go, b_go, a_w, b_w, a_r, b_r, ev;
        logic [31:0] d;
        #1;
        coll = ia1.chipselect && ia1.write && ib1.chipselect && ib1.write && (ia1.address == ib1.address);
        checks++;
        if (ia1.waitrequest !== 1'b0) begin
            errors++; $display("FAIL a_waitrequest: got %b expected 0", ia1.waitrequest);
        end
        checks++;
        if (ib1.waitrequest !== coll) begin
            errors++; $display("FAIL b_waitrequest: got %b expected %b", ib1.waitrequest, coll);
        end
        a_go = ia1.chipselect && (ia1.read || ia1.write);
        b_go = ib1.chipselect && (ib1.read || ib1.write) && !coll;
        a_w = a_go && ia1.write;  a_r = a_go && ia1.read && !ia1.write;
        b_w = b_go && ib1.write;  b_r = b_go && ib1.read && !ib1.write;
        if (a_r) begin
            d = m1[ia1.address];
            if (b_w && ib1.address == ia1.address) d = merge(d, ib1.writedata, ib1.byteenable);
            qa.push_back('{cyc + 1, d});
        end
        if (b_r) begin
            d = m1[ib1.address];
            if (a_w && ia1.address == ib1.address) d = merge(d, ia1.writedata, ia1.byteenable);
            qb.push_back('{cyc + 1, d});
        end
        if (a_w) m1[ia1.address] = merge(m1[ia1.address], ia1.writedata, ia1.byteenable);
        if (b_w) m1[ib1.address] = merge(m1[ib1.address], ib1.writedata, ib1.byteenable);
        b_stalled = coll;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        ev = 1'b0;
        if (qa.size() > 0) ev = (qa[0].due == cyc);
        checks++;
        if (ia1.readdatavalid !== ev) begin
            errors++; $display("FAIL a_readdatavalid: got %b expected %b (cycle %0d)", ia1.readdatavalid, ev, cyc);
        end
        if (ev) begin last_a = qa[0].data; void'(qa.pop_front()); va_cnt++; end
        checks++;
        if (ia1.readdata !== last_a) begin
            errors++; $display("FAIL a_readdata: got %h expected %h (cycle %0d)", ia1.readdata, last_a, cyc);
        end
        ev = 1'b0;
        if (qb.size() > 0) ev = (qb[0].due == cyc);
        checks++;
        if (ib1.readdatavalid !== ev) begin
            errors++; $display("FAIL b_readdatavalid: got %b expected %b (cycle %0d)", ib1.readdatavalid, ev, cyc);
        end
        if (ev) begin last_b = qb[0].data; void'(qb.pop_front()); vb_cnt++; end
        checks++;
        if (ib1.readdata !== last_b) begin
            errors++; $display("FAIL b_readdata: got %h expected %h (cycle %0d)", ib1.readdata, last_b, cyc);
        end
    endtask

    // Called at the negedge where reset_n was just released.
    task automatic test_release();
`ifdef QSYS_DP_DATA_MEM_SCRUB_EN
        int unsigned n;
        int unsigned m;
        n = 0;
        while (ia2.waitrequest === 1'b1 && n < 64) begin n++; @(negedge clk); end
        checks++;
        if (n != 16) begin errors++; $display("FAIL scrub_cycles_16: got %0d expected 16", n); end
        m = n;
        while (ia1.waitrequest === 1'b1 && m < 600) begin m++; @(negedge clk); end
        checks++;
        if (m != 256) begin errors++; $display("FAIL scrub_cycles_256: got %0d expected 256", m); end
        foreach (m1[i]) m1[i] = '0;
`endif
        checks++;
        if ({ia1.waitrequest, ib1.waitrequest, ia2.waitrequest, ib2.waitrequest} !== 4'b0000) begin
            errors++;
            $display("FAIL release_waitrequest: got %b%b%b%b expected 0000",
                     ia1.waitrequest, ib1.waitrequest, ia2.waitrequest, ib2.waitrequest);
        end
    endtask

    task automatic test_reset();
        logic exp_w;
`ifdef QSYS_DP_DATA_MEM_SCRUB_EN
        exp_w = 1'b1;
`else
        exp_w = 1'b0;
`endif
        drv_a1(0, 0, 0, 0, 0, 0); drv_b1(0, 0, 0, 0, 0, 0); idle2();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ia1.readdatavalid, ia1.readdata} !== 33'd0) begin
            errors++; $display("FAIL reset_a1: got %b/%h expected 0/0", ia1.readdatavalid, ia1.readdata);
        end
        checks++;
        if ({ib1.readdatavalid, ib1.readdata} !== 33'd0) begin
            errors++; $display("FAIL reset_b1: got %b/%h expected 0/0", ib1.readdatavalid, ib1.readdata);
        end
        checks++;
        if ({ia2.readdatavalid, ia2.readdata, ib2.readdatavalid, ib2.readdata} !== 66'd0) begin
            errors++; $display("FAIL reset_dut2: got %b/%h %b/%h expected zeros",
                               ia2.readdatavalid, ia2.readdata, ib2.readdatavalid, ib2.readdata);
        end
        checks++;
        if (ia1.waitrequest !== exp_w || ib1.waitrequest !== exp_w) begin
            errors++; $display("FAIL reset_waitrequest: got %b%b expected %b%b",
                               ia1.waitrequest, ib1.waitrequest, exp_w, exp_w);
        end
        reset_n = 1'b1;
        test_release();
    endtask

`ifdef QSYS_DP_DATA_MEM_SCRUB_EN
    task automatic test_scrub();
        for (int i = 0; i < 16; i++) begin
            drv_a1(1, 1, 0, 8'(i), 0, 0); drv_b1(1, 1, 0, 8'(255 - i), 0, 0);
            tick1();
            ia2.chipselect = 1; ia2.read = 1; ia2.address = 4'(i);
            @(negedge clk);
            idle2();
            @(negedge clk);
            checks++;
            if (ia2.readdatavalid !== 1'b1 || ia2.readdata !== 32'h0) begin
                errors++; $display("FAIL scrub_zero_read: got %b/%h expected 1/00000000",
                                   ia2.readdatavalid, ia2.readdata);
            end
        end
        drv_a1(0, 0, 0, 0, 0, 0); drv_b1(0, 0, 0, 0, 0, 0);
        tick1();
    endtask
`endif

    task automatic test_fill();
        for (int i = 0; i < 256; i++) begin
            drv_a1(1, 0, 1, 8'(i), 4'hF, $urandom);
            tick1();
        end
        drv_a1(0, 0, 0, 0, 0, 0);
        tick1();
    endtask

    task automatic test_basic();
        drv_a1(1, 0, 1, 8'd5, 4'hF, 32'hDEADBEEF); tick1();
        drv_a1(1, 1, 0, 8'd5, 4'h0, 32'h0);        tick1();
        checks++;
        if (ia1.readdatavalid !== 1'b1 || ia1.readdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_read: got %b/%h expected 1/deadbeef", ia1.readdatavalid, ia1.readdata);
        end
        drv_a1(0, 0, 0, 0, 0, 0); tick1();
        checks++;
        if (ia1.readdatavalid !== 1'b0 || ia1.readdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_hold: got %b/%h expected 0/deadbeef", ia1.readdatavalid, ia1.readdata);
        end
        drv_a1(1, 1, 1, 8'd11, 4'hF, 32'hCAFEF00D); tick1();
        checks++;
        if (ia1.readdatavalid !== 1'b0) begin
            errors++; $display("FAIL read_write_same_port: got valid %b expected 0", ia1.readdatavalid);
        end
        drv_a1(1, 1, 0, 8'd11, 4'h0, 32'h0); tick1();
        checks++;
        if (ia1.readdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL read_write_committed: got %h expected cafef00d", ia1.readdata);
        end
        drv_a1(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_byteen();
        drv_a1(1, 0, 1, 8'd7, 4'hF, 32'h11223344); tick1();
        drv_a1(0, 0, 0, 0, 0, 0);
        drv_b1(1, 0, 1, 8'd7, 4'b0101, 32'hAABBCCDD); tick1();
        drv_b1(1, 0, 1, 8'd7, 4'b0000, 32'hFFFFFFFF); tick1();
        drv_b1(1, 1, 0, 8'd7, 4'b0000, 32'h0);        tick1();
        checks++;
        if (ib1.readdatavalid !== 1'b1 || ib1.readdata !== 32'h11BB33DD) begin
            errors++; $display("FAIL byteenable_merge: got %b/%h expected 1/11bb33dd", ib1.readdatavalid, ib1.readdata);
        end
        drv_b1(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_rdw();
        drv_a1(1, 0, 1, 8'd9, 4'hF, 32'h0); tick1();
        drv_a1(1, 0, 1, 8'd9, 4'b1100, 32'hFFFF0000);
        drv_b1(1, 1, 0, 8'd9, 4'b0000, 32'h0);
        tick1();
        checks++;
        if (ib1.readdatavalid !== 1'b1 || ib1.readdata !== 32'hFFFF0000) begin
            errors++; $display("FAIL rdw_b_reads: got %b/%h expected 1/ffff0000", ib1.readdatavalid, ib1.readdata);
        end
        drv_b1(1, 0, 1, 8'd9, 4'b0011, 32'h12345678);
        drv_a1(1, 1, 0, 8'd9, 4'b0000, 32'h0);
        tick1();
        checks++;
        if (ia1.readdatavalid !== 1'b1 || ia1.readdata !== 32'hFFFF5678) begin
            errors++; $display("FAIL rdw_a_reads: got %b/%h expected 1/ffff5678", ia1.readdatavalid, ia1.readdata);
        end
        drv_a1(0, 0, 0, 0, 0, 0); drv_b1(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_collision();
        drv_a1(1, 0, 1, 8'd3, 4'hF, 32'h1);
        drv_b1(1, 0, 1, 8'd3, 4'hF, 32'h2);
        #1;
        checks++;
        if (ib1.waitrequest !== 1'b1) begin
            errors++; $display("FAIL collision_stall: got %b expected 1", ib1.waitrequest);
        end
        tick1();
        drv_a1(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (ib1.waitrequest !== 1'b0) begin
            errors++; $display("FAIL collision_one_cycle: got %b expected 0", ib1.waitrequest);
        end
        tick1();
        drv_b1(0, 0, 0, 0, 0, 0);
        drv_a1(1, 1, 0, 8'd3, 4'h0, 32'h0);
        tick1();
        checks++;
        if (ia1.readdata !== 32'h2) begin
            errors++; $display("FAIL collision_readback: got %h expected 00000002", ia1.readdata);
        end
        drv_a1(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int unsigned va0, vb0;
        va0 = va_cnt; vb0 = vb_cnt;
        for (int i = 0; i < 8; i++) begin
            drv_a1(1, 1, 0, 8'(i), 0, 0);
            drv_b1(1, 1, 0, 8'(7 - i), 0, 0);
            tick1();
        end
        drv_a1(0, 0, 0, 0, 0, 0); drv_b1(0, 0, 0, 0, 0, 0);
        repeat (2) tick1();
        checks++;
        if (va_cnt - va0 != 8 || vb_cnt - vb0 != 8) begin
            errors++; $display("FAIL back_to_back_count: got %0d/%0d expected 8/8", va_cnt - va0, vb_cnt - vb0);
        end
    endtask

    task automatic test_random();
        int unsigned op;
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 3);
            drv_a1(op != 0, op[0], op[1], 8'($urandom_range(0, 15)), 4'($urandom), $urandom);
            if (!b_stalled) begin
                op = $urandom_range(0, 3);
                drv_b1(op != 0, op[0], op[1], 8'($urandom_range(0, 15)), 4'($urandom), $urandom);
            end
            tick1();
        end
        drv_a1(0, 0, 0, 0, 0, 0); drv_b1(0, 0, 0, 0, 0, 0);
        repeat (3) tick1();
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++; $display("FAIL random_drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
        end
    endtask

    task automatic test_lat2();
        logic [31:0] v [4];
        logic        exp_v;
        logic [31:0] exp_d;
        for (int i = 0; i < 4; i++) begin
            v[i] = $urandom;
            ia2.chipselect = 1; ia2.read = 0; ia2.write = 1;
            ia2.address = 4'(i); ia2.byteenable = 4'hF; ia2.writedata = v[i];
            @(negedge clk);
        end
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) begin
                ia2.chipselect = 1; ia2.read = 1; ia2.write = 0; ia2.address = 4'(k - 1);
            end else begin
                idle2();
            end
            @(negedge clk);
            exp_v = (k >= 2 && k <= 5);
            checks++;
            if (ia2.readdatavalid !== exp_v) begin
                errors++; $display("FAIL lat2_valid: got %b expected %b (step %0d)", ia2.readdatavalid, exp_v, k);
            end
            exp_d = (k >= 2 && k <= 5) ? v[k - 2] : v[3];
            if (k >= 2) begin
                checks++;
                if (ia2.readdata !== exp_d) begin
                    errors++; $display("FAIL lat2_data: got %h expected %h (step %0d)", ia2.readdata, exp_d, k);
                end
            end
        end
        ia2.chipselect = 1; ia2.read = 1; ia2.address = 4'd1;
        @(negedge clk);
        ia2.address = 4'd2;
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (ia2.readdatavalid !== 1'b0 || ia2.readdata !== 32'h0 || ia1.readdata !== 32'h0) begin
                errors++; $display("FAIL reset_flush: got %b/%h a1=%h expected 0/00000000 a1=00000000",
                                   ia2.readdatavalid, ia2.readdata, ia1.readdata);
            end
            idle2();
            @(negedge clk);
        end
        reset_n = 1'b1;
        last_a = '0; last_b = '0; qa.delete(); qb.delete();
        test_release();
        drv_a1(1, 1, 0, 8'd5, 0, 0); drv_b1(1, 1, 0, 8'd7, 0, 0);
        tick1();
        drv_a1(0, 0, 0, 0, 0, 0); drv_b1(0, 0, 0, 0, 0, 0);
        tick1();
        ia2.chipselect = 1; ia2.read = 1; ia2.address = 4'd0;
        @(negedge clk);
        idle2();
        @(negedge clk);
`ifdef QSYS_DP_DATA_MEM_SCRUB_EN
        exp_d = 32'h0;
`else
        exp_d = v[0];
`endif
        checks++;
        if (ia2.readdatavalid !== 1'b1 || ia2.readdata !== exp_d) begin
            errors++; $display("FAIL lat2_retained: got %b/%h expected 1/%h", ia2.readdatavalid, ia2.readdata, exp_d);
        end
    endtask

    initial begin
        test_reset();
`ifdef QSYS_DP_DATA_MEM_SCRUB_EN
        test_scrub();
`endif
        test_fill();
        test_basic();
        test_byteen();
        test_rdw();
        test_collision();
        test_back_to_back();
        test_random();
        test_lat2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
